clockdivider_prog: RTL and testbench
====================================

# clockdivider_prog

Parametrised, multi-channel programmable clock divider; the next-generation replacement for the fixed /2, /4, /8 divider. Each of NCH channels divides `clock` by a run-time programmable integer divisor (even or odd), has its own enable, and emits a registered divided clock plus a one-cycle period-start tick. Divisors are updated through a valid/ready config port and take effect only at a period boundary, so channel outputs never produce truncated periods. Reset defaults reproduce the legacy /2, /4, /8 outputs on channels 0..2.

## Interface
- `NCH`, 3: number of channels, 1..DIV_W-1.
- `DIV_W`, 8: divisor/counter width in bits.
- `CH_W`, max(1, clog2(NCH)): width of the channel select.
- `clock` in 1: sole clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `en` in NCH: per-channel run enable.
- `cfg_valid` in 1: config write request.
- `cfg_ch` in CH_W: target channel.
- `cfg_div` in DIV_W: new divisor.
- `cfg_ready` out 1: write accepted on an edge where cfg_valid & cfg_ready.
- `divided_clk` out NCH: divided clock per channel, registered.
- `tick` out NCH: one-cycle pulse, high in the first cycle of each divided period, registered.

## Operation
- Per-channel state: phase `p` (DIV_W), `cur_div`, `pend_div`, `pending`, `running`.
- Reset values: `cur_div[i] = 2^(i+1) mod 2^DIV_W`; `p=0`, `pending=0`, `running=0`, `divided_clk=0`, `tick=0`.
- Channel is active when `en[i]=1` and `cur_div[i] >= 2`. Divisor 0 or 1 means halted.
- On each edge, an active channel computes `p_next = 0` if `running=0` or `p = cur_div-1`; otherwise `p_next = p+1`. The channel then sets `running <= 1`.
- Boundary: `p_next = 0`. At a boundary with `pending=1`, `cur_div <= pend_div` and `pending <= 0`. The new divisor governs the period that starts at that edge.
- Outputs are taken from `p_next` and the divisor in effect: `divided_clk <= (p_next < ceil(D/2))`; `tick <= (p_next == 0)`. Period is exactly D cycles. High time is ceil(D/2) and low time is floor(D/2); for example D=5 gives 11100.
- Inactive channel (en=0 or halted): `p<=0`, `running<=0`, `divided_clk<=0`, `tick<=0`. Any pending divisor is applied on the next edge (`cur_div<=pend_div`, `pending<=0`).
- Config port:
  - `cfg_ready = ~pending[cfg_ch]`, combinational.
  - On accept: `pend_div[cfg_ch] <= cfg_div` and `pending[cfg_ch] <= 1`.
  - When `cfg_ch >= NCH`: `cfg_ready=1` and the write is dropped with no state change.
- Simultaneous accept and boundary on the same channel and edge: the current boundary uses the old `pending` (0). The newly accepted value is applied at the following boundary.
- A write is not accepted while that channel is pending; the master holds `cfg_valid` until `cfg_ready` goes high. Writes to other channels proceed independently.
- Channels are fully independent; no phase alignment between channels is guaranteed except after a common reset or a common enable edge.

## Timing
- Enable rise: on the first edge with `en[i]=1` sampled, `divided_clk[i]` and `tick[i]` go 1 (phase 0).
- Enable fall: on the first edge with `en[i]=0` sampled, both outputs go 0, mid-period if necessary. Re-enable restarts at phase 0.
- Divisor update latency: the new period begins at the first boundary strictly after the accept edge. Worst case is cur_div cycles after accept.
- `pending` clears on that boundary edge, so `cfg_ready` is high in the following cycle.
- Async reset: all outputs 0 immediately on assertion, independent of `clock`. First active edge after deassertion behaves as an enable rise.

## Test plan
- **Defaults:** reset, `en=3'b111`, 16 cycles.
  - ch0 = 1010…; ch1 = 1100…; ch2 = 11110000…
  - `tick` high at phases 0 only: every 2, 4 and 8 cycles respectively.
- **Odd divisor:** write ch0 div=5 while disabled, then enable.
  - `divided_clk[0]` = 11100 repeating; `tick[0]` every 5 cycles.
- **Mid-period update:** ch1 running /4; write div=3 at phase 1.
  - Current 1100 period completes, then 110 repeats.
  - `cfg_ready` is 0 from accept until the boundary edge.
  - A second write to ch1 held meanwhile is accepted only after that edge; a write to ch2 is accepted immediately.
- **Boundary collision:** accept ch1 div=6 on the exact boundary edge.
  - One more old period, then 111000 repeats.
- **Enable and halt:**
  - Drop `en[2]` at phase 5: output low next edge; re-enable restarts with 1111.
  - Write div=1 then div=0: channel stays low, no ticks.
  - Out-of-range `cfg_ch=3`: no effect.
- **Reset mid-run:** assert `reset` between edges mid-period.
  - All outputs 0 immediately, divisors revert to 2/4/8.
  - After release, channels restart in phase.

Source files
------------

// File: rtl/clockdivider_prog.sv
// Multi-channel programmable clock divider.
// Each channel divides clock by a run-time divisor (even or odd), has its own
// run enable, and emits a registered divided clock plus a period-start tick.
// New divisors arrive through a valid/ready port, are parked as "pending",
// and only take effect at a period boundary so no period is ever truncated.
// Reset divisors reproduce the legacy /2, /4, /8 outputs on channels 0..2.
module clockdivider_prog #(
  parameter int NCH   = 3,
  parameter int DIV_W = 8,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_valid,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic [NCH-1:0]   divided_clk,
  output logic [NCH-1:0]   tick
);

  logic [NCH-1:0] pendingVec;

  // Ready reflects the addressed channel's pending flag; unknown channels
  // always look ready so a stray write is swallowed instead of stalling.
  always_comb begin
    cfg_ready = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (cfg_ch == CH_W'(k)) begin
        cfg_ready = ~pendingVec[k];
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : gCh
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(64'd1 << (i + 1));

    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] curDiv_q, curDiv_d;
    logic [DIV_W-1:0] pendDiv_q, pendDiv_d;
    logic             pending_q, pending_d;
    logic             running_q, running_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic             active;
    logic             accept;
    logic             boundary;
    logic [DIV_W-1:0] pNext;
    logic [DIV_W-1:0] divEff;
    logic [DIV_W:0]   highLen;

    assign active = en[i] && (curDiv_q >= DIV_W'(2));
    assign accept = cfg_valid && (cfg_ch == CH_W'(i)) && !pending_q;

    // Phase advance: a fresh start or the last phase of a period wraps to 0,
    // and the divisor for the period starting there is the pending one if any.
    always_comb begin
      pNext = '0;
      if (running_q && (phase_q != curDiv_q - DIV_W'(1))) begin
        pNext = phase_q + DIV_W'(1);
      end
      boundary = (pNext == '0);
      divEff   = (boundary && pending_q) ? pendDiv_q : curDiv_q;
      highLen  = ({1'b0, divEff} + (DIV_W + 1)'(1)) >> 1;
    end

    // Next-state for the channel; a config accept is evaluated last so that
    // a write landing on a boundary edge waits for the following boundary.
    always_comb begin
      phase_d   = phase_q;
      curDiv_d  = curDiv_q;
      pendDiv_d = pendDiv_q;
      pending_d = pending_q;
      running_d = running_q;
      clk_d     = clk_q;
      tick_d    = tick_q;
      if (active) begin
        phase_d   = pNext;
        running_d = 1'b1;
        clk_d     = ({1'b0, pNext} < highLen);
        tick_d    = boundary;
        if (boundary && pending_q) begin
          curDiv_d  = pendDiv_q;
          pending_d = 1'b0;
        end
      end else begin
        phase_d   = '0;
        running_d = 1'b0;
        clk_d     = 1'b0;
        tick_d    = 1'b0;
        if (pending_q) begin
          curDiv_d  = pendDiv_q;
          pending_d = 1'b0;
        end
      end
      if (accept) begin
        pendDiv_d = cfg_div;
        pending_d = 1'b1;
      end
    end

    // Channel state register; reset restores the legacy power-of-two divisor.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        phase_q   <= '0;
        curDiv_q  <= RST_DIV;
        pendDiv_q <= '0;
        pending_q <= 1'b0;
        running_q <= 1'b0;
        clk_q     <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        phase_q   <= phase_d;
        curDiv_q  <= curDiv_d;
        pendDiv_q <= pendDiv_d;
        pending_q <= pending_d;
        running_q <= running_d;
        clk_q     <= clk_d;
        tick_q    <= tick_d;
      end
    end

    assign pendingVec[i]  = pending_q;
    assign divided_clk[i] = clk_q;
    assign tick[i]        = tick_q;
  end

endmodule

// File: tb/tb_clockdivider_prog.sv
// Self-checking bench for clockdivider_prog: expected per-cycle output
// patterns are queued when stimulus is driven and compared as edges occur.
module tb_clockdivider_prog;

  logic       clock;
  logic       reset;
  logic [2:0] en;
  logic       cfgValid;
  logic [1:0] cfgCh;
  logic [7:0] cfgDiv;
  logic       cfgReady;
  logic [2:0] dividedClk;
  logic [2:0] tick;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    string      tag;
    logic [2:0] clkV;
    logic [2:0] tickV;
    logic [2:0] mask;
  } expT;

  expT expQ[$];

  clockdivider_prog #(.NCH(3), .DIV_W(8), .CH_W(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .cfg_valid  (cfgValid),
    .cfg_ch     (cfgCh),
    .cfg_div    (cfgDiv),
    .cfg_ready  (cfgReady),
    .divided_clk(dividedClk),
    .tick       (tick)
  );

  // Free-running 10-unit clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic pushCycle(input string tag, input logic [2:0] clkV, input logic [2:0] tickV, input logic [2:0] mask);
    expT e;
    e.tag   = tag;
    e.clkV  = clkV;
    e.tickV = tickV;
    e.mask  = mask;
    expQ.push_back(e);
  endtask

  task automatic pushSeq(input string tag, input int ch, input string clkS, input string tickS);
    logic [2:0] c3;
    logic [2:0] t3;
    logic [2:0] m3;
    for (int c = 0; c < clkS.len(); c++) begin
      c3 = '0;
      t3 = '0;
      m3 = '0;
      c3[ch] = (clkS[c] == "1");
      t3[ch] = (tickS[c] == "1");
      m3[ch] = 1'b1;
      pushCycle(tag, c3, t3, m3);
    end
  endtask

  task automatic pushDefaults(input string tag);
    string c0 = "10";
    string c1 = "1100";
    string c2 = "11110000";
    string t0 = "10";
    string t1 = "1000";
    string t2 = "10000000";
    logic [2:0] cv;
    logic [2:0] tv;
    for (int c = 0; c < 16; c++) begin
      cv = {c2[c % 8] == "1", c1[c % 4] == "1", c0[c % 2] == "1"};
      tv = {t2[c % 8] == "1", t1[c % 4] == "1", t0[c % 2] == "1"};
      pushCycle(tag, cv, tv, 3'b111);
    end
  endtask

  task automatic applyStimulus(input int n);
    expT e;
    repeat (n) begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.tag, "Clk"}, 32'(dividedClk & e.mask), 32'(e.clkV));
        checkOutput({e.tag, "Tick"}, 32'(tick & e.mask), 32'(e.tickV));
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    en       = 3'b000;
    cfgValid = 1'b0;
    cfgCh    = 2'd0;
    cfgDiv   = 8'd0;

    // Reset state
    #2;
    checkOutput("rstClk", 32'(dividedClk), 32'h0);
    checkOutput("rstTick", 32'(tick), 32'h0);
    checkOutput("rstReady", 32'(cfgReady), 32'h1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    en    = 3'b111;

    // Legacy /2 /4 /8 defaults
    pushDefaults("dflt");
    applyStimulus(16);

    // Odd divisor written while disabled
    en       = 3'b000;
    cfgCh    = 2'd0;
    cfgDiv   = 8'd5;
    cfgValid = 1'b1;
    #1;
    checkOutput("oddRdy", 32'(cfgReady), 32'h1);
    pushCycle("oddOff", 3'b000, 3'b000, 3'b111);
    pushCycle("oddOff", 3'b000, 3'b000, 3'b111);
    applyStimulus(1);
    cfgValid = 1'b0;
    #1;
    checkOutput("oddPend", 32'(cfgReady), 32'h0);
    applyStimulus(1);
    en = 3'b001;
    pushSeq("odd", 0, "111001110011100", "100001000010000");
    applyStimulus(15);

    // Mid-period update on ch1, held second write, independent ch2 write
    en = 3'b010;
    pushSeq("mid", 1, "1100110101010", "1000100101010");
    applyStimulus(1);
    cfgCh    = 2'd1;
    cfgDiv   = 8'd3;
    cfgValid = 1'b1;
    applyStimulus(1);
    checkOutput("midRdyBusy", 32'(cfgReady), 32'h0);
    cfgCh  = 2'd2;
    cfgDiv = 8'd8;
    #1;
    checkOutput("ch2RdyFree", 32'(cfgReady), 32'h1);
    applyStimulus(1);
    cfgCh  = 2'd1;
    cfgDiv = 8'd2;
    #1;
    checkOutput("heldRdyA", 32'(cfgReady), 32'h0);
    applyStimulus(1);
    checkOutput("heldRdyB", 32'(cfgReady), 32'h0);
    applyStimulus(1);
    checkOutput("rdyAfterBnd", 32'(cfgReady), 32'h1);
    applyStimulus(1);
    cfgValid = 1'b0;
    #1;
    checkOutput("heldAccepted", 32'(cfgReady), 32'h0);
    applyStimulus(2);
    checkOutput("rdyAfterApply", 32'(cfgReady), 32'h1);
    applyStimulus(5);

    // Accept landing exactly on a boundary edge
    cfgCh    = 2'd1;
    cfgDiv   = 8'd6;
    cfgValid = 1'b1;
    pushSeq("coll", 1, "10111000111000", "10100000100000");
    applyStimulus(1);
    cfgValid = 1'b0;
    #1;
    checkOutput("collRdy", 32'(cfgReady), 32'h0);
    applyStimulus(13);

    // Enable drop at phase 5 and restart on ch2
    en = 3'b100;
    pushSeq("en", 2, "1111000111100001", "1000000100000001");
    applyStimulus(6);
    en = 3'b000;
    applyStimulus(1);
    en = 3'b100;
    applyStimulus(9);

    // Halt with divisor 1, then divisor 0
    en       = 3'b000;
    cfgCh    = 2'd2;
    cfgDiv   = 8'd1;
    cfgValid = 1'b1;
    #1;
    checkOutput("halt1Rdy", 32'(cfgReady), 32'h1);
    pushSeq("halt1", 2, "000000000000", "000000000000");
    applyStimulus(1);
    cfgValid = 1'b0;
    applyStimulus(1);
    en = 3'b100;
    applyStimulus(10);
    cfgDiv   = 8'd0;
    cfgValid = 1'b1;
    pushSeq("halt0", 2, "000000", "000000");
    applyStimulus(1);
    cfgValid = 1'b0;
    applyStimulus(5);

    // Out-of-range channel select is swallowed
    cfgCh    = 2'd3;
    cfgDiv   = 8'd4;
    cfgValid = 1'b1;
    #1;
    checkOutput("oorRdy", 32'(cfgReady), 32'h1);
    pushSeq("oor", 2, "00", "00");
    applyStimulus(2);
    cfgValid = 1'b0;
    cfgCh    = 2'd2;
    #1;
    checkOutput("oorCh2Rdy", 32'(cfgReady), 32'h1);

    // Halted channel revives with divisor 3
    cfgDiv   = 8'd3;
    cfgValid = 1'b1;
    pushSeq("revive", 2, "00110110", "00100100");
    applyStimulus(1);
    cfgValid = 1'b0;
    applyStimulus(7);

    // Asynchronous reset mid-period
    en = 3'b000;
    applyStimulus(1);
    en = 3'b111;
    pushCycle("preRst", 3'b111, 3'b111, 3'b111);
    applyStimulus(1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("rstAsyncClk", 32'(dividedClk), 32'h0);
    checkOutput("rstAsyncTick", 32'(tick), 32'h0);
    @(posedge clock);
    #1;
    checkOutput("rstHoldClk", 32'(dividedClk), 32'h0);
    #3;
    reset = 1'b0;
    pushDefaults("post");
    applyStimulus(16);

    checkOutput("sbEmpty", 32'(expQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
